// File: rtl/dram_line_requester_if.sv
// Request/response and DRAM-side signals of the line requester, bundled for port hookup.
// slave = the requester itself; master = the cache/DRAM side that drives requests and MEM_DOUT.
interface dram_line_requester_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 128
) ();
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [AWIDTH-1:0] REQ_ADDR;
  logic [DWIDTH-1:0] REQ_WDATA;
  logic              RESP_VALID;
  logic              RESP_WE;
  logic [DWIDTH-1:0] RESP_RDATA;
  logic              MEM_CSN;
  logic              MEM_WEN;
  logic [AWIDTH-1:0] MEM_ADDR;
  logic [DWIDTH-1:0] MEM_DI;
  logic [DWIDTH-1:0] MEM_DOUT;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_DOUT,
    output REQ_READY, RESP_VALID, RESP_WE, RESP_RDATA,
           MEM_CSN, MEM_WEN, MEM_ADDR, MEM_DI
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_DOUT,
    input  REQ_READY, RESP_VALID, RESP_WE, RESP_RDATA,
           MEM_CSN, MEM_WEN, MEM_ADDR, MEM_DI
  );
endinterface

// File: rtl/dram_line_requester.sv
// DRAM line requester: valid/ready line requests in, one-cycle CSN strobe out, fixed-latency completion.
// Optional macro DRAM_REQ_STATS_EN adds saturating read/write/busy counters (STAT_RD/STAT_WR/STAT_BUSY).
module dram_line_requester #(
  parameter int AWIDTH  = 10,
  parameter int DWIDTH  = 128,
  parameter int LATENCY = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  dram_line_requester_if.slave bus
`ifdef DRAM_REQ_STATS_EN
  ,
  output logic [31:0]          STAT_RD,
  output logic [31:0]          STAT_WR,
  output logic [31:0]          STAT_BUSY
`endif
);

  typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_WAIT} state_t;

  localparam int CNT_W = 4;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                csn_q, csn_d;
  logic                wen_q, wen_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   di_q, di_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_we_q, resp_we_d;
  logic [DWIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                cur_we_q, cur_we_d;
  logic                buf_full_q, buf_full_d;
  logic                buf_we_q, buf_we_d;
  logic [AWIDTH-1:0]   buf_addr_q, buf_addr_d;
  logic [DWIDTH-1:0]   buf_wdata_q, buf_wdata_d;

  logic                accept;
  logic                issue_en;
  logic                issue_we;
  logic [AWIDTH-1:0]   issue_addr;
  logic [DWIDTH-1:0]   issue_wdata;

  assign accept = bus.REQ_VALID && ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    csn_d        = 1'b1;
    wen_d        = wen_q;
    addr_d       = addr_q;
    di_d         = di_q;
    resp_valid_d = 1'b0;
    resp_we_d    = resp_we_q;
    resp_rdata_d = resp_rdata_q;
    cur_we_d     = cur_we_q;
    buf_full_d   = buf_full_q;
    buf_we_d     = buf_we_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    issue_en     = 1'b0;
    issue_we     = bus.REQ_WE;
    issue_addr   = bus.REQ_ADDR;
    issue_wdata  = bus.REQ_WDATA;

    case (state_q)
      S_DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE: begin
        issue_en = accept;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_we_d    = cur_we_q;
          if (!cur_we_q) begin
            resp_rdata_d = bus.MEM_DOUT;
          end
          // A queued request takes priority; otherwise a same-edge accept goes straight out.
          if (buf_full_q) begin
            issue_en    = 1'b1;
            issue_we    = buf_we_q;
            issue_addr  = buf_addr_q;
            issue_wdata = buf_wdata_q;
            buf_full_d  = 1'b0;
          end else if (accept) begin
            issue_en = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (accept) begin
            buf_full_d  = 1'b1;
            buf_we_d    = bus.REQ_WE;
            buf_addr_d  = bus.REQ_ADDR;
            buf_wdata_d = bus.REQ_WDATA;
          end
        end
      end
      default: begin
        state_d = S_DRAIN;
        cnt_d   = CNT_W'(LATENCY);
      end
    endcase

    if (issue_en) begin
      csn_d    = 1'b0;
      wen_d    = ~issue_we;
      addr_d   = issue_addr;
      di_d     = issue_wdata;
      cur_we_d = issue_we;
      cnt_d    = CNT_W'(LATENCY - 1);
      state_d  = S_WAIT;
    end

    ready_d = (state_d == S_IDLE) || ((state_d == S_WAIT) && !buf_full_d);
  end

`ifdef DRAM_REQ_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_busy_q, stat_busy_d;

  always_comb begin
    stat_rd_d   = stat_rd_q;
    stat_wr_d   = stat_wr_q;
    stat_busy_d = stat_busy_q;
    if (resp_valid_q && !resp_we_q && (stat_rd_q != '1)) begin
      stat_rd_d = stat_rd_q + 32'd1;
    end
    if (resp_valid_q && resp_we_q && (stat_wr_q != '1)) begin
      stat_wr_d = stat_wr_q + 32'd1;
    end
    if ((state_q == S_WAIT) && (stat_busy_q != '1)) begin
      stat_busy_d = stat_busy_q + 32'd1;
    end
  end

  assign STAT_RD   = stat_rd_q;
  assign STAT_WR   = stat_wr_q;
  assign STAT_BUSY = stat_busy_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_DRAIN;
      cnt_q        <= CNT_W'(LATENCY);
      ready_q      <= 1'b0;
      csn_q        <= 1'b1;
      wen_q        <= 1'b1;
      addr_q       <= '0;
      di_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
      cur_we_q     <= 1'b0;
      buf_full_q   <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
`ifdef DRAM_REQ_STATS_EN
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_busy_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      csn_q        <= csn_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      di_q         <= di_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
      cur_we_q     <= cur_we_d;
      buf_full_q   <= buf_full_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
`ifdef DRAM_REQ_STATS_EN
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_busy_q  <= stat_busy_d;
`endif
    end
  end

  assign bus.REQ_READY  = ready_q;
  assign bus.RESP_VALID = resp_valid_q;
  assign bus.RESP_WE    = resp_we_q;
  assign bus.RESP_RDATA = resp_rdata_q;
  assign bus.MEM_CSN    = csn_q;
  assign bus.MEM_WEN    = wen_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.MEM_DI     = di_q;

endmodule
